// File: rtl/gpr_ctrl_pkg.sv
// Shared constants and types for the general-purpose register file write-back path.
// Imported by the arbiter top level and the pending scoreboard.
package gpr_ctrl_pkg;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 4;
   localparam int NUM_REGS = 16;

   // Which write-back stream was granted most recently; the other one wins the next tie.
   typedef enum logic {
      GRANT_ALU = 1'b0,
      GRANT_MEM = 1'b1
   } grant_e;

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register pending-write scoreboard with orphan write-back detection.
// Set on issue, cleared when the register file write enable retires the register.
module gpr_scoreboard
   import gpr_ctrl_pkg::*;
#(
   parameter int ADDR_W   = gpr_ctrl_pkg::ADDR_W,
   parameter int NUM_REGS = gpr_ctrl_pkg::NUM_REGS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                issue_valid,
   input  logic [ADDR_W-1:0]   issue_dest,
   input  logic                reg_write_en,
   input  logic [ADDR_W-1:0]   reg_write_dest,
   output logic [NUM_REGS-1:0] pending,
   output logic                wb_orphan
);

   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;
   logic [NUM_REGS-1:0] pending_nxt;
   logic                orphan_hit;

   // Set is applied after clear: a same-cycle issue names a younger producer.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (issue_valid) begin
         set_mask[issue_dest] = 1'b1;
      end
      if (reg_write_en) begin
         clr_mask[reg_write_dest] = 1'b1;
      end
      pending_nxt = (pending & ~clr_mask) | set_mask;
   end

   // Checked against the pending bit as it stood before this edge's update.
   assign orphan_hit = reg_write_en && !pending[reg_write_dest];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending   <= '0;
         wb_orphan <= 1'b0;
      end else begin
         pending <= pending_nxt;
         if (orphan_hit) begin
            wb_orphan <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Round-robin write-back arbiter (ALU vs. memory load) driving the single register file
// write port from a registered output stage, plus the pending scoreboard for hazard stalls.
module gpr_wb_arbiter
   import gpr_ctrl_pkg::*;
#(
   parameter int DATA_W   = gpr_ctrl_pkg::DATA_W,
   parameter int ADDR_W   = gpr_ctrl_pkg::ADDR_W,
   parameter int NUM_REGS = gpr_ctrl_pkg::NUM_REGS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                alu_wb_valid,
   input  logic [ADDR_W-1:0]   alu_wb_dest,
   input  logic [DATA_W-1:0]   alu_wb_data,
   output logic                alu_wb_ready,
   input  logic                mem_wb_valid,
   input  logic [ADDR_W-1:0]   mem_wb_dest,
   input  logic [DATA_W-1:0]   mem_wb_data,
   output logic                mem_wb_ready,
   input  logic                issue_valid,
   input  logic [ADDR_W-1:0]   issue_dest,
   output logic                reg_write_en,
   output logic [ADDR_W-1:0]   reg_write_dest,
   output logic [DATA_W-1:0]   reg_write_data,
   output logic [NUM_REGS-1:0] pending,
   output logic                wb_orphan,
   output grant_e              last_grant
);

   // Handshake: a write-back transfers at a rising edge where valid && ready. A requester
   // keeps dest/data stable while valid and not ready; ready depends only on the valids
   // and last_grant, never on anything registered downstream.

   grant_e            last_grant_nxt;
   logic              alu_xfer;
   logic              mem_xfer;
   logic              any_xfer;
   logic [ADDR_W-1:0] win_dest;
   logic [DATA_W-1:0] win_data;

   // The write port is free every cycle, so the only refusal is losing a tie.
   always_comb begin
      alu_wb_ready = 1'b0;
      mem_wb_ready = 1'b0;
      if (alu_wb_valid && mem_wb_valid) begin
         alu_wb_ready = (last_grant == GRANT_MEM);
         mem_wb_ready = (last_grant == GRANT_ALU);
      end else begin
         alu_wb_ready = alu_wb_valid;
         mem_wb_ready = mem_wb_valid;
      end
   end

   assign alu_xfer = alu_wb_valid && alu_wb_ready;
   assign mem_xfer = mem_wb_valid && mem_wb_ready;
   assign any_xfer = alu_xfer || mem_xfer;

   always_comb begin
      last_grant_nxt = last_grant;
      win_dest       = reg_write_dest;
      win_data       = reg_write_data;
      if (alu_xfer) begin
         last_grant_nxt = GRANT_ALU;
         win_dest       = alu_wb_dest;
         win_data       = alu_wb_data;
      end else if (mem_xfer) begin
         last_grant_nxt = GRANT_MEM;
         win_dest       = mem_wb_dest;
         win_data       = mem_wb_data;
      end
   end

   // Reset to MEM so the ALU wins the first tie after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= GRANT_MEM;
      end else begin
         last_grant <= last_grant_nxt;
      end
   end

   // Output stage; dest/data hold when idle, and reset drops any write in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_write_en   <= 1'b0;
         reg_write_dest <= '0;
         reg_write_data <= '0;
      end else begin
         reg_write_en   <= any_xfer;
         reg_write_dest <= win_dest;
         reg_write_data <= win_data;
      end
   end

   gpr_scoreboard #(
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_scoreboard (
      .clk            (clk),
      .rst            (rst),
      .issue_valid    (issue_valid),
      .issue_dest     (issue_dest),
      .reg_write_en   (reg_write_en),
      .reg_write_dest (reg_write_dest),
      .pending        (pending),
      .wb_orphan      (wb_orphan)
   );

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed table-driven bench for gpr_wb_arbiter, plus hand sequences for
// asynchronous reset mid-write and round-robin alternation from reset.
module tb_gpr_wb_arbiter;
   import gpr_ctrl_pkg::*;

   logic          clk;
   logic          rst;
   logic          alu_wb_valid;
   logic [3:0]    alu_wb_dest;
   logic [15:0]   alu_wb_data;
   logic          alu_wb_ready;
   logic          mem_wb_valid;
   logic [3:0]    mem_wb_dest;
   logic [15:0]   mem_wb_data;
   logic          mem_wb_ready;
   logic          issue_valid;
   logic [3:0]    issue_dest;
   logic          reg_write_en;
   logic [3:0]    reg_write_dest;
   logic [15:0]   reg_write_data;
   logic [15:0]   pending;
   logic          wb_orphan;
   grant_e        last_grant;

   int n_tests = 0;
   int n_fail  = 0;

   gpr_wb_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .alu_wb_valid   (alu_wb_valid),
      .alu_wb_dest    (alu_wb_dest),
      .alu_wb_data    (alu_wb_data),
      .alu_wb_ready   (alu_wb_ready),
      .mem_wb_valid   (mem_wb_valid),
      .mem_wb_dest    (mem_wb_dest),
      .mem_wb_data    (mem_wb_data),
      .mem_wb_ready   (mem_wb_ready),
      .issue_valid    (issue_valid),
      .issue_dest     (issue_dest),
      .reg_write_en   (reg_write_en),
      .reg_write_dest (reg_write_dest),
      .reg_write_data (reg_write_data),
      .pending        (pending),
      .wb_orphan      (wb_orphan),
      .last_grant     (last_grant)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Each row: inputs driven for one cycle, and the expected readies (combinational from
   // those inputs) together with the registered outputs left by the previous row's edge.
   typedef struct {
      logic        alu_v;
      logic [3:0]  alu_d;
      logic [15:0] alu_x;
      logic        mem_v;
      logic [3:0]  mem_d;
      logic [15:0] mem_x;
      logic        iss_v;
      logic [3:0]  iss_d;
      logic        e_ar;
      logic        e_mr;
      logic        e_we;
      logic [3:0]  e_dest;
      logic [15:0] e_data;
      logic [15:0] e_pend;
      logic        e_orph;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic av, input logic [3:0] ad, input logic [15:0] ax,
                          input logic mv, input logic [3:0] md, input logic [15:0] mx,
                          input logic iv, input logic [3:0] id,
                          input logic ear, input logic emr, input logic ewe,
                          input logic [3:0] edest, input logic [15:0] edata,
                          input logic [15:0] epend, input logic eorph);
      vec_t v;
      v.alu_v = av;  v.alu_d = ad;  v.alu_x = ax;
      v.mem_v = mv;  v.mem_d = md;  v.mem_x = mx;
      v.iss_v = iv;  v.iss_d = id;
      v.e_ar = ear;  v.e_mr = emr;  v.e_we = ewe;
      v.e_dest = edest;  v.e_data = edata;  v.e_pend = epend;  v.e_orph = eorph;
      vecs.push_back(v);
   endtask

   // Scoreboard check
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Driver tasks
   task automatic drive(input logic av, input logic [3:0] ad, input logic [15:0] ax,
                        input logic mv, input logic [3:0] md, input logic [15:0] mx,
                        input logic iv, input logic [3:0] id);
      alu_wb_valid = av;  alu_wb_dest = ad;  alu_wb_data = ax;
      mem_wb_valid = mv;  mem_wb_dest = md;  mem_wb_data = mx;
      issue_valid  = iv;  issue_dest  = id;
   endtask

   task automatic drive_idle();
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
   endtask

   initial begin
      rst = 1'b1;
      drive_idle();
      repeat (2) @(negedge clk);
      // Reset state
      check("reset_we",     {31'd0, reg_write_en}, 32'd0);
      check("reset_dest",   {28'd0, reg_write_dest}, 32'd0);
      check("reset_data",   {16'd0, reg_write_data}, 32'd0);
      check("reset_pend",   {16'd0, pending}, 32'd0);
      check("reset_orphan", {31'd0, wb_orphan}, 32'd0);
      check("reset_lg",     {31'd0, last_grant}, {31'd0, GRANT_MEM});
      rst = 1'b0;

      // av ad ax       mv md mx       iv id    ar mr we dest data     pend     orph
      add_vec(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd0, 0, 0, 0, 4'd0, 16'h0000, 16'h0000, 0);
      add_vec(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, 4'd3, 0, 0, 0, 4'd0, 16'h0000, 16'h0000, 0);
      add_vec(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, 4'd1, 0, 0, 0, 4'd0, 16'h0000, 16'h0008, 0);
      add_vec(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, 4'd2, 0, 0, 0, 4'd0, 16'h0000, 16'h000A, 0);
      add_vec(1, 4'd3, 16'h1234, 0, 4'd0, 16'h0000, 0, 4'd0, 1, 0, 0, 4'd0, 16'h0000, 16'h000E, 0);
      add_vec(1, 4'd1, 16'hAAAA, 1, 4'd2, 16'h5555, 0, 4'd0, 0, 1, 1, 4'd3, 16'h1234, 16'h000E, 0);
      add_vec(1, 4'd1, 16'hAAAA, 1, 4'd2, 16'h5555, 1, 4'd2, 1, 0, 1, 4'd2, 16'h5555, 16'h0006, 0);
      add_vec(1, 4'd1, 16'hAAAA, 1, 4'd2, 16'h5555, 0, 4'd0, 0, 1, 1, 4'd1, 16'hAAAA, 16'h0006, 0);
      add_vec(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd0, 0, 0, 1, 4'd2, 16'h5555, 16'h0004, 0);
      add_vec(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd0, 0, 0, 0, 4'd2, 16'h5555, 16'h0000, 0);
      add_vec(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, 4'd5, 0, 0, 0, 4'd2, 16'h5555, 16'h0000, 0);
      add_vec(1, 4'd5, 16'h0BEE, 0, 4'd0, 16'h0000, 0, 4'd0, 1, 0, 0, 4'd2, 16'h5555, 16'h0020, 0);
      add_vec(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd0, 0, 0, 1, 4'd5, 16'h0BEE, 16'h0020, 0);
      add_vec(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd0, 0, 0, 0, 4'd5, 16'h0BEE, 16'h0000, 0);
      add_vec(0, 4'd0, 16'h0000, 1, 4'd9, 16'h9999, 0, 4'd0, 0, 1, 0, 4'd5, 16'h0BEE, 16'h0000, 0);
      add_vec(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd0, 0, 0, 1, 4'd9, 16'h9999, 16'h0000, 0);
      add_vec(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd0, 0, 0, 0, 4'd9, 16'h9999, 16'h0000, 1);
      add_vec(1, 4'd4, 16'h4444, 0, 4'd0, 16'h0000, 1, 4'd4, 1, 0, 0, 4'd9, 16'h9999, 16'h0000, 1);
      add_vec(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd0, 0, 0, 1, 4'd4, 16'h4444, 16'h0010, 1);
      add_vec(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd0, 0, 0, 0, 4'd4, 16'h4444, 16'h0000, 1);
      add_vec(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, 4'd6, 0, 0, 0, 4'd4, 16'h4444, 16'h0000, 1);
      add_vec(1, 4'd6, 16'h6001, 0, 4'd0, 16'h0000, 1, 4'd6, 1, 0, 0, 4'd4, 16'h4444, 16'h0040, 1);
      add_vec(0, 4'd0, 16'h0000, 1, 4'd6, 16'h6002, 0, 4'd0, 0, 1, 1, 4'd6, 16'h6001, 16'h0040, 1);
      add_vec(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd0, 0, 0, 1, 4'd6, 16'h6002, 16'h0000, 1);
      add_vec(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd0, 0, 0, 0, 4'd6, 16'h6002, 16'h0000, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].alu_v, vecs[i].alu_d, vecs[i].alu_x,
               vecs[i].mem_v, vecs[i].mem_d, vecs[i].mem_x,
               vecs[i].iss_v, vecs[i].iss_d);
         #1;
         check($sformatf("v%0d_alu_ready", i), {31'd0, alu_wb_ready}, {31'd0, vecs[i].e_ar});
         check($sformatf("v%0d_mem_ready", i), {31'd0, mem_wb_ready}, {31'd0, vecs[i].e_mr});
         check($sformatf("v%0d_we", i),        {31'd0, reg_write_en}, {31'd0, vecs[i].e_we});
         check($sformatf("v%0d_dest", i),      {28'd0, reg_write_dest}, {28'd0, vecs[i].e_dest});
         check($sformatf("v%0d_data", i),      {16'd0, reg_write_data}, {16'd0, vecs[i].e_data});
         check($sformatf("v%0d_pending", i),   {16'd0, pending}, {16'd0, vecs[i].e_pend});
         check($sformatf("v%0d_orphan", i),    {31'd0, wb_orphan}, {31'd0, vecs[i].e_orph});
      end

      // Asynchronous reset while a write sits in the output stage
      @(negedge clk);
      drive(1'b1, 4'd8, 16'h8888, 1'b0, 4'd0, 16'h0, 1'b1, 4'd8);
      @(negedge clk);
      drive_idle();
      #1;
      check("arst_pre_we",   {31'd0, reg_write_en}, 32'd1);
      check("arst_pre_pend", {16'd0, pending}, 32'h0000_0100);
      #1;
      rst = 1'b1;
      #1;
      check("arst_we",     {31'd0, reg_write_en}, 32'd0);
      check("arst_dest",   {28'd0, reg_write_dest}, 32'd0);
      check("arst_data",   {16'd0, reg_write_data}, 32'd0);
      check("arst_pend",   {16'd0, pending}, 32'd0);
      check("arst_orphan", {31'd0, wb_orphan}, 32'd0);
      check("arst_lg",     {31'd0, last_grant}, {31'd0, GRANT_MEM});
      @(negedge clk);
      rst = 1'b0;

      // Persistent tie from reset: ALU first, then strict alternation
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(1'b1, 4'd1, 16'hAAAA, 1'b1, 4'd2, 16'h5555, 1'b0, 4'd0);
         #1;
         check($sformatf("rr%0d_alu_ready", i), {31'd0, alu_wb_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
         check($sformatf("rr%0d_mem_ready", i), {31'd0, mem_wb_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
         if (i > 0) begin
            check($sformatf("rr%0d_prev_dest", i), {28'd0, reg_write_dest}, (i % 2 == 1) ? 32'd1 : 32'd2);
         end
      end
      @(negedge clk);
      drive_idle();
      #1;
      check("rr_last_we",   {31'd0, reg_write_en}, 32'd1);
      check("rr_last_dest", {28'd0, reg_write_dest}, 32'd2);
      check("rr_last_data", {16'd0, reg_write_data}, 32'h0000_5555);

      // Final report
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global time limit so the run always ends
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/gpr_wb_arbiter.md
# gpr_wb_arbiter

Write-back controller for the 16 x 16-bit general-purpose register file, which has a single write port. Arbitrates round-robin between the ALU and memory-load write-back streams and drives the register file write port from a registered output stage. Keeps a per-register pending scoreboard so issue logic can stall on read-after-write hazards.

## Interface
Parameters:
- DATA_W, 16, register data width
- ADDR_W, 4, register address width
- NUM_REGS, 16, register count (2**ADDR_W)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- alu_wb_valid  in  1  ALU write-back request
- alu_wb_dest  in  ADDR_W  ALU destination register
- alu_wb_data  in  DATA_W  ALU result
- alu_wb_ready  out  1  ALU request accepted this cycle
- mem_wb_valid  in  1  load write-back request
- mem_wb_dest  in  ADDR_W  load destination register
- mem_wb_data  in  DATA_W  load data
- mem_wb_ready  out  1  load request accepted this cycle
- issue_valid  in  1  instruction issued that will write issue_dest
- issue_dest  in  ADDR_W  destination to mark pending
- reg_write_en  out  1  to register file write enable
- reg_write_dest  out  ADDR_W  to register file write address
- reg_write_data  out  DATA_W  to register file write data
- pending  out  NUM_REGS  bit i = register i has an outstanding write
- wb_orphan  out  1  sticky: write-back to a non-pending register occurred

## Operation
- Valid/ready handshake; transfer when valid && ready at a rising edge. A requester holds dest/data stable while valid and not ready.
- The write port is free every cycle, so at most one request is refused per cycle, and only because of a conflict.
- Grant rule, combinational from the valids and last_grant:
  - Only one requester valid: it gets ready = 1.
  - Both valid: the requester not named by last_grant wins; the loser's ready = 0.
  - Neither valid: both readies = 0.
- last_grant state has two values, ALU or MEM. It updates to the winner on every transfer and holds when there is no transfer.
- Output stage, updated every edge:
  - reg_write_en <= any transfer
  - reg_write_dest / reg_write_data <= the winner's fields
  - dest and data hold their previous value when there is no transfer.
- Scoreboard, per edge:
  - issue_valid sets pending[issue_dest].
  - reg_write_en clears pending[reg_write_dest].
  - Set and clear on the same register in the same cycle: set wins, because the new producer is younger.
- wb_orphan is set at the edge where reg_write_en is high and pending[reg_write_dest] = 0 (sampled before that edge's update). It clears only on rst. The write is still performed.
- Register 0 is an ordinary register: writable and tracked.

## Timing
- Reset values: alu_wb_ready/mem_wb_ready follow the valids combinationally. reg_write_en = 0, reg_write_dest = 0, reg_write_data = 0, pending = 0, wb_orphan = 0, last_grant = MEM (the ALU wins the first tie).
- Latency, for a transfer at edge N:
  - reg_write_en is high during cycle N+1.
  - The register file captures the data at edge N+1.
  - pending for that register reads 0 from cycle N+2, when register file read data is already new. pending never clears before the data is readable.
- Throughput: one write-back per cycle. Back-to-back conflicts alternate ALU, MEM, ALU, ...
- Reset asserted mid-operation: all state clears immediately and asynchronously. A write held in the output stage is dropped: reg_write_en falls without waiting for clk.
- The same destination written by both streams in consecutive cycles: both writes issue in grant order, and the later one lands last.

## Structure
- Shared package gpr_ctrl_pkg holds:
  - DATA_W, ADDR_W, NUM_REGS constants
  - grant enum {GRANT_ALU, GRANT_MEM}
- Sub-module gpr_scoreboard holds:
  - the pending vector
  - the set/clear priority logic
  - the wb_orphan detection
- Its inputs are issue_valid/issue_dest and reg_write_en/reg_write_dest.
- The top level holds the arbiter, last_grant and the output stage.

## Test plan
- After reset: ALU-only request dest=3 data=0x1234 -> alu_wb_ready=1; next cycle reg_write_en=1, dest=3, data=0x1234.
- Both valid, persistently, ALU dest=1/0xAAAA and MEM dest=2/0x5555 -> grants ALU, MEM, ALU, MEM. A waiting requester never waits more than one cycle.
- issue_valid dest=5, then ALU write-back dest=5 accepted at edge N -> pending[5]=1 through cycle N+1, 0 from cycle N+2; wb_orphan stays 0.
- issue_valid dest=7 in the same cycle reg_write_en clears dest 7 -> pending[7] stays 1.
- Write-back dest=9 with pending[9]=0 -> write performed and wb_orphan=1, which persists until rst.
- rst asserted asynchronously while reg_write_en=1 -> reg_write_en, pending and wb_orphan go 0 before the next clk edge.
